util_cpack2_timestamp: RTL and testbench

ADC-side counterpart of the DAC timestamp gate. It sits between the cpack2 packed output and the ADC DMA write port, in the ADC clock domain. Every `timestamp_every` data blocks it inserts one 64-bit timestamp block ahead of the data. The DMA buffer therefore has the same layout the TX path consumes: one timestamp block followed by N data blocks. A small internal FIFO absorbs the extra slot taken by each inserted block and drains during input idle cycles.

---
 rtl/util_cpack2_timestamp.sv | 169 ++++++++++++++++
 tb/tb_util_cpack2_timestamp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/util_cpack2_timestamp.sv
// Inserts one 64-bit timestamp block ahead of every timestamp_every data blocks on the ADC DMA path.
// Optional drop counter enabled by defining UTIL_CPACK2_TIMESTAMP_DROP_COUNT_EN.
module util_cpack2_timestamp #(
  parameter int NUM_OF_CHANNELS     = 4,
  parameter int SAMPLES_PER_CHANNEL = 1,
  parameter int SAMPLE_DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH_LOG2     = 3
) (
  input  logic                                                          adc_clk,
  input  logic                                                          reset,
  input  logic [63:0]                                                   timestamp,
  input  logic [31:0]                                                   timestamp_every,
  input  logic                                                          s_axis_valid,
  input  logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] s_axis_data,
  input  logic                                                          s_axis_xfer_req,
  output logic                                                          m_axis_valid,
  output logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] m_axis_data,
  output logic                                                          m_axis_overflow,
  output logic [31:0]                                                   drop_count
);

  localparam int DW    = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int EW    = 1 + 64 + DW;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  logic [EW-1:0]              fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       xfer_q;
  logic [31:0]                every_q, every_d, blk_cnt_q, blk_cnt_d;
  logic                       force_ts_q, force_ts_d, ts_sent_q, ts_sent_d;
  logic                       m_valid_q, m_valid_d, overflow_q, overflow_d;
  logic [DW-1:0]              m_data_q, m_data_d;

  logic          rise, full, push, pop, flag;
  logic [31:0]   every_eff, blk_next;
  logic [EW-1:0] head;

  always_comb begin
    rise      = s_axis_xfer_req & ~xfer_q;
    // A block arriving on the activation cycle already uses the new period.
    every_eff = rise ? timestamp_every : every_q;
    full      = (count_q == DEPTH_CNT);
    head      = fifo_mem[rd_ptr_q];
    blk_next  = ((every_eff == 32'd0) || (blk_cnt_q == every_eff - 32'd1)) ? 32'd0 : blk_cnt_q + 32'd1;

    every_d    = every_eff;
    blk_cnt_d  = blk_cnt_q;
    force_ts_d = force_ts_q;
    ts_sent_d  = ts_sent_q;
    m_valid_d  = 1'b0;
    m_data_d   = m_data_q;
    overflow_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flag       = 1'b0;

    if (!s_axis_xfer_req) begin
      blk_cnt_d  = 32'd0;
      force_ts_d = 1'b0;
      ts_sent_d  = 1'b0;
    end else begin
      if (count_q != '0) begin
        m_valid_d = 1'b1;
        if (head[EW-1] && !ts_sent_q) begin
          m_data_d       = '0;
          m_data_d[63:0] = head[DW +: 64];
          ts_sent_d      = 1'b1;
        end else begin
          m_data_d  = head[DW-1:0];
          pop       = 1'b1;
          ts_sent_d = 1'b0;
        end
      end
      // Full is judged on pre-pop occupancy, so a concurrent pop does not save the block.
      if (s_axis_valid) begin
        if (full) begin
          overflow_d = 1'b1;
          force_ts_d = 1'b1;
          blk_cnt_d  = blk_next;
        end else begin
          push = 1'b1;
          flag = (every_eff != 32'd0) && ((blk_cnt_q == 32'd0) || force_ts_q);
          if (force_ts_q) begin
            blk_cnt_d  = (every_eff <= 32'd1) ? 32'd0 : 32'd1;
            force_ts_d = 1'b0;
          end else begin
            blk_cnt_d = blk_next;
          end
        end
      end
    end

    if (!s_axis_xfer_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(push);
      rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(pop);
      count_d  = count_q + (FIFO_DEPTH_LOG2 + 1)'(push) - (FIFO_DEPTH_LOG2 + 1)'(pop);
    end
  end

  always_ff @(posedge adc_clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_q] <= {flag, timestamp, s_axis_data};
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_q     <= 1'b0;
      every_q    <= 32'd0;
      blk_cnt_q  <= 32'd0;
      force_ts_q <= 1'b0;
      ts_sent_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_q     <= s_axis_xfer_req;
      every_q    <= every_d;
      blk_cnt_q  <= blk_cnt_d;
      force_ts_q <= force_ts_d;
      ts_sent_q  <= ts_sent_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_axis_valid    = m_valid_q;
  assign m_axis_data     = m_data_q;
  assign m_axis_overflow = overflow_q;

`ifdef UTIL_CPACK2_TIMESTAMP_DROP_COUNT_EN
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (rise) begin
      drop_count_d = 32'd0;
    end else if (overflow_d && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_d = drop_count_q + 32'd1;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      drop_count_q <= 32'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_util_cpack2_timestamp.sv
// Randomised scoreboard bench for util_cpack2_timestamp: a queue-based reference model predicts
// the output stream and overflow pulses; a monitor compares whenever the DUT presents them.
module tb_util_cpack2_timestamp;

  localparam int NCH   = 4;
  localparam int SPC   = 1;
  localparam int SDW   = 32;
  localparam int DLOG2 = 3;
  localparam int DW    = NCH * SPC * SDW;
  localparam int DEPTH = 1 << DLOG2;
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic          adc_clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   timestamp = 64'd0;
  logic [31:0]   timestamp_every = 32'd0;
  logic          s_axis_valid = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_xfer_req = 1'b0;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_overflow;
  logic [31:0]   drop_count;

  util_cpack2_timestamp #(
    .NUM_OF_CHANNELS(NCH), .SAMPLES_PER_CHANNEL(SPC),
    .SAMPLE_DATA_WIDTH(SDW), .FIFO_DEPTH_LOG2(DLOG2)
  ) dut (
    .adc_clk(adc_clk), .reset(reset), .timestamp(timestamp),
    .timestamp_every(timestamp_every), .s_axis_valid(s_axis_valid),
    .s_axis_data(s_axis_data), .s_axis_xfer_req(s_axis_xfer_req),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
    .m_axis_overflow(m_axis_overflow), .drop_count(drop_count)
  );

  always #5 adc_clk = ~adc_clk;

  int cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
  typedef struct { bit flag; logic [63:0] ts; logic [DW-1:0] data; } ent_t;

  exp_t exp_q[$];
  int   ovf_q[$];
  ent_t buf_m[$];

  int tests = 0;
  int fails = 0;

  bit          m_prev_xfer = 1'b0;
  logic [31:0] m_every = 32'd0;
  int unsigned m_pos = 0;
  bit          m_force = 1'b0;
  bit          m_ts_sent = 1'b0;
  logic [31:0] m_drops = 32'd0;
  logic [31:0] exp_dc = 32'd0;
  bit          dc_armed = 1'b0;
  bit          chk_zero = 1'b0;
  logic [31:0] ts_hi = 32'd0;

  // Predicts the effect of the upcoming clock edge; expectations are tagged with the cycle they appear.
  task automatic model_step();
    int   t;
    bit   rise;
    bit   was_full;
    int unsigned start;
    ent_t ent;
    exp_t e;
    t = cyc + 1;
    if (reset) begin
      buf_m.delete();
      m_prev_xfer = 1'b0; m_every = 32'd0; m_pos = 0;
      m_force = 1'b0; m_ts_sent = 1'b0; m_drops = 32'd0;
      return;
    end
    rise = s_axis_xfer_req && !m_prev_xfer;
    m_prev_xfer = s_axis_xfer_req;
    if (rise) begin
      m_every = timestamp_every;
      m_drops = 32'd0;
    end
    if (!s_axis_xfer_req) begin
      buf_m.delete();
      m_pos = 0; m_force = 1'b0; m_ts_sent = 1'b0;
      return;
    end
    was_full = (buf_m.size() == DEPTH);
    if (buf_m.size() > 0) begin
      e.cyc = t;
      if (buf_m[0].flag && !m_ts_sent) begin
        e.data = DW'(buf_m[0].ts);
        m_ts_sent = 1'b1;
      end else begin
        e.data = buf_m[0].data;
        void'(buf_m.pop_front());
        m_ts_sent = 1'b0;
      end
      exp_q.push_back(e);
    end
    if (s_axis_valid) begin
      if (was_full) begin
        ovf_q.push_back(t);
        m_force = 1'b1;
        if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
        m_pos = (m_every == 0) ? 0 : (m_pos + 1) % m_every;
      end else begin
        ent.flag = (m_every != 0) && (m_pos == 0 || m_force);
        ent.ts   = timestamp;
        ent.data = s_axis_data;
        buf_m.push_back(ent);
        // A resync block is position 0 of a fresh period.
        start   = m_force ? 0 : m_pos;
        m_force = 1'b0;
        m_pos   = (m_every == 0) ? 0 : (start + 1) % m_every;
      end
    end
  endtask

  task automatic step(input bit r, input bit x, input logic [31:0] ev, input bit v);
    logic [DW-1:0] d;
    @(negedge adc_clk);
    if (dc_armed) begin
      tests++;
      if (drop_count !== exp_dc) begin
        fails++;
        $display("FAIL drop_count cyc=%0d got %0d expected %0d", cyc, drop_count, exp_dc);
      end
    end
    if (chk_zero) begin
      tests++;
      if (m_axis_valid !== 1'b0 || m_axis_data !== '0 || m_axis_overflow !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got valid=%b data=%h ovf=%b expected all 0",
                 cyc, m_axis_valid, m_axis_data, m_axis_overflow);
      end
      chk_zero = 1'b0;
    end
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    reset           = r;
    s_axis_xfer_req = x;
    timestamp_every = ev;
    s_axis_valid    = v;
    s_axis_data     = d;
    timestamp       = {ts_hi, 32'd100 + 32'(cyc)};
    model_step();
    exp_dc   = DC_EN ? m_drops : 32'd0;
    dc_armed = 1'b1;
    if (r) chk_zero = 1'b1;
  endtask

  always @(negedge adc_clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL missing_output cyc=%0d got nothing expected data=%h", exp_q[0].cyc, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    if (m_axis_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_output cyc=%0d got data=%h expected no output", cyc, m_axis_data);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_data !== e.data) begin
          fails++;
          $display("FAIL output_data cyc=%0d got %h expected %h", cyc, m_axis_data, e.data);
        end
      end
    end
    while (ovf_q.size() > 0 && ovf_q[0] < cyc) begin
      tests++; fails++;
      $display("FAIL missing_overflow cyc=%0d got 0 expected 1", ovf_q[0]);
      void'(ovf_q.pop_front());
    end
    if (m_axis_overflow === 1'b1) begin
      tests++;
      if (ovf_q.size() == 0 || ovf_q[0] != cyc) begin
        fails++;
        $display("FAIL unexpected_overflow cyc=%0d got 1 expected 0", cyc);
      end else begin
        void'(ovf_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] ev_r;
    bit          x_r;
    int          sel;
    // Reset state
    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Pass-through, insertion disabled
    repeat (2) step(0, 1, 0, 0);
    repeat (5) begin step(0, 1, 0, 1); step(0, 1, 0, 0); end
    repeat (4) step(0, 1, 0, 0);
    // Period of 3, alternate-cycle input
    repeat (2) step(0, 0, 3, 0);
    repeat (12) begin step(0, 1, 3, 1); step(0, 1, 3, 0); end
    repeat (6) step(0, 1, 3, 0);
    // Sustained input, period 4: fills and drops
    repeat (2) step(0, 0, 4, 0);
    repeat (40) step(0, 1, 4, 1);
    repeat (30) step(0, 1, 4, 0);
    // Re-activation clears the drop counter
    repeat (2) step(0, 0, 4, 0);
    repeat (3) step(0, 1, 4, 0);
    // Flush with entries queued, then reactivate with period 2
    repeat (7) step(0, 1, 2, 1);
    repeat (3) step(0, 0, 2, 0);
    repeat (6) begin step(0, 1, 2, 1); step(0, 1, 2, 0); end
    repeat (6) step(0, 1, 2, 0);
    // Reset mid-burst with xfer_req held
    repeat (2) step(0, 0, 3, 0);
    repeat (6) step(0, 1, 3, 1);
    step(1, 1, 3, 1);
    repeat (6) begin step(0, 1, 3, 1); step(0, 1, 3, 0); end
    repeat (10) step(0, 1, 3, 0);
    // Random traffic
    x_r  = 1'b1;
    ev_r = 32'd3;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        x_r = ~x_r;
        if (x_r) begin
          sel = $urandom_range(0, 5);
          ev_r = (sel == 5) ? 32'd7 : 32'(sel);
        end
      end
      if ($urandom_range(0, 31) == 0) ts_hi = $urandom;
      step($urandom_range(0, 399) == 0, x_r, ev_r, $urandom_range(0, 9) < 7);
    end
    repeat (30) step(0, 1, ev_r, 0);
    repeat (3) step(0, 0, ev_r, 0);
    @(negedge adc_clk);
    tests++;
    if (exp_q.size() != 0 || ovf_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations got %0d outputs %0d overflows pending expected 0",
               exp_q.size(), ovf_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
